// File: rtl/stage_mem_sram_if.sv
// Half-word SRAM bus between the memory stage (master) and the external SRAM (slave).
interface stage_mem_sram_if #(
  parameter int SRAM_AW = 18
);
  logic [SRAM_AW-1:0] sramAddr;
  logic [15:0]        sramDqOut;
  logic [15:0]        sramDqIn;
  logic               sramDqOe;
  logic               sramWeN;

  modport master (
    output sramAddr,
    output sramDqOut,
    output sramDqOe,
    output sramWeN,
    input  sramDqIn
  );

  modport slave (
    input  sramAddr,
    input  sramDqOut,
    input  sramDqOe,
    input  sramWeN,
    output sramDqIn
  );
endinterface

// File: rtl/stage_mem_sram.sv
// Memory stage: 32-bit loads/stores as lo/hi half-word SRAM phases; non-mem ops pass in 1 cycle.
// ready drops for 1 + 2*(SRAM_WAIT+1) cycles per mem op, then is high for a single DONE cycle.
module stage_mem_sram #(
  parameter int ADDR_BASE = 1024,
  parameter int SRAM_WAIT = 2,
  parameter int SRAM_AW   = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbEnIn,
  input  logic        memREnIn,
  input  logic        memWEnIn,
  input  logic [31:0] aluResIn,
  input  logic [31:0] valRmIn,
  input  logic [3:0]  destIn,
  output logic        ready,
  output logic        wbEnOut,
  output logic        memREnOut,
  output logic [31:0] aluResOut,
  output logic [31:0] memDataOut,
  output logic [3:0]  destOut,
  stage_mem_sram_if.master sram
);

  localparam int CW = (SRAM_WAIT > 0) ? $clog2(SRAM_WAIT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(SRAM_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [15:0]        dq_q, dq_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;
  logic [15:0]        lo_q, lo_d;
  logic [15:0]        hi_q, hi_d;
  logic               wb_en_q, wb_en_d;
  logic               mem_ren_q, mem_ren_d;
  logic [31:0]        alu_res_q, alu_res_d;
  logic [31:0]        mem_data_q, mem_data_d;
  logic [3:0]         dest_q, dest_d;

  logic               mem_op;
  logic               is_store;
  logic               is_load;
  logic [SRAM_AW-2:0] word_addr;

  assign mem_op    = memREnIn | memWEnIn;
  assign is_store  = memWEnIn;
  assign is_load   = memREnIn & ~memWEnIn;
  // Offset from the SRAM window, wrapped mod 2^32, then byte->word and truncated.
  assign word_addr = (SRAM_AW-1)'((aluResIn - 32'(ADDR_BASE)) >> 2);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    dq_d       = dq_q;
    oe_d       = oe_q;
    we_n_d     = we_n_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    wb_en_d    = wb_en_q;
    mem_ren_d  = mem_ren_q;
    alu_res_d  = alu_res_q;
    mem_data_d = mem_data_q;
    dest_d     = dest_q;

    ready = ((state_q == S_IDLE) && !mem_op) || (state_q == S_DONE);

    if (ready) begin
      wb_en_d   = wbEnIn;
      mem_ren_d = memREnIn;
      alu_res_d = aluResIn;
      dest_d    = destIn;
      if ((state_q == S_DONE) && is_load) begin
        mem_data_d = {hi_q, lo_q};
      end
    end

    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          state_d = S_LO;
          cnt_d   = '0;
          addr_d  = {word_addr, 1'b0};
          dq_d    = valRmIn[15:0];
          oe_d    = is_store;
          we_n_d  = ~is_store;
        end
      end
      S_LO: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_HI;
          cnt_d   = '0;
          lo_d    = sram.sramDqIn;
          addr_d  = {word_addr, 1'b1};
          dq_d    = valRmIn[31:16];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HI: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          hi_d    = sram.sramDqIn;
          oe_d    = 1'b0;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        // The pipeline advances on this edge, so IDLE sees the next instruction.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      dq_q       <= '0;
      oe_q       <= 1'b0;
      we_n_q     <= 1'b1;
      lo_q       <= '0;
      hi_q       <= '0;
      wb_en_q    <= 1'b0;
      mem_ren_q  <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      dq_q       <= dq_d;
      oe_q       <= oe_d;
      we_n_q     <= we_n_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      wb_en_q    <= wb_en_d;
      mem_ren_q  <= mem_ren_d;
      alu_res_q  <= alu_res_d;
      mem_data_q <= mem_data_d;
      dest_q     <= dest_d;
    end
  end

  assign sram.sramAddr  = addr_q;
  assign sram.sramDqOut = dq_q;
  assign sram.sramDqOe  = oe_q;
  assign sram.sramWeN   = we_n_q;

  assign wbEnOut    = wb_en_q;
  assign memREnOut  = mem_ren_q;
  assign aluResOut  = alu_res_q;
  assign memDataOut = mem_data_q;
  assign destOut    = dest_q;

endmodule

// File: tb/tb_stage_mem_sram.sv
// Bench for stage_mem_sram: emulated SRAM device plus a word-level reference memory.
module tb_stage_mem_sram;
  localparam int ADDR_BASE = 1024;
  localparam int SRAM_WAIT = 2;
  localparam int SRAM_AW   = 18;
  localparam int PHASE     = SRAM_WAIT + 1;
  localparam int STALL     = 1 + 2 * PHASE;

  logic        clk = 1'b0;
  logic        rst;
  logic        wbEnIn, memREnIn, memWEnIn;
  logic [31:0] aluResIn, valRmIn;
  logic [3:0]  destIn;
  logic        ready, wbEnOut, memREnOut;
  logic [31:0] aluResOut, memDataOut;
  logic [3:0]  destOut;

  always #5 clk = ~clk;

  stage_mem_sram_if #(.SRAM_AW(SRAM_AW)) sif ();

  stage_mem_sram #(
    .ADDR_BASE(ADDR_BASE),
    .SRAM_WAIT(SRAM_WAIT),
    .SRAM_AW  (SRAM_AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wbEnIn    (wbEnIn),
    .memREnIn  (memREnIn),
    .memWEnIn  (memWEnIn),
    .aluResIn  (aluResIn),
    .valRmIn   (valRmIn),
    .destIn    (destIn),
    .ready     (ready),
    .wbEnOut   (wbEnOut),
    .memREnOut (memREnOut),
    .aluResOut (aluResOut),
    .memDataOut(memDataOut),
    .destOut   (destOut),
    .sram      (sif.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Device: a write lands only after the strobe is held on one address for a full phase.
  logic [15:0] dev [int];
  int          wr_run = 0;
  logic [SRAM_AW-1:0] wr_addr = '0;

  // Reference: 32-bit words keyed by SRAM word index.
  logic [31:0] ref_word [int];
  logic [31:0] exp_mem_data = '0;

  function automatic logic [15:0] dev_rd(int a);
    return dev.exists(a) ? dev[a] : 16'h0000;
  endfunction

  function automatic int word_of(logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return int'((off / 4) % (1 << (SRAM_AW - 1)));
  endfunction

  initial sif.sramDqIn = 16'h0000;

  always @(negedge clk) begin
    if (sif.sramWeN === 1'b0) begin
      if (wr_run > 0 && sif.sramAddr == wr_addr) wr_run++;
      else wr_run = 1;
      wr_addr = sif.sramAddr;
      if (wr_run == PHASE) dev[int'(sif.sramAddr)] = sif.sramDqOut;
    end else begin
      wr_run = 0;
    end
    sif.sramDqIn = dev_rd(int'(sif.sramAddr));
  end

  task automatic do_op(input string nm, input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] rm, input logic [3:0] dest);
    int low = 0;
    int bus_err = 0;
    int wi;
    int ph;
    bit mem;
    mem = r | w;
    wi  = word_of(alu);
    wbEnIn = wb; memREnIn = r; memWEnIn = w;
    aluResIn = alu; valRmIn = rm; destIn = dest;
    if (mem && w) ref_word[wi] = rm;
    else if (mem) exp_mem_data = ref_word.exists(wi) ? ref_word[wi] : 32'h0;
    while (1) begin
      @(negedge clk);
      if (ready === 1'b1) break;
      low++;
      if (low > 1 && low <= STALL) begin
        ph = (low > 1 + PHASE) ? 1 : 0;
        if (sif.sramAddr !== SRAM_AW'(2 * wi + ph)) bus_err++;
        if (w) begin
          if (sif.sramWeN !== 1'b0 || sif.sramDqOe !== 1'b1) bus_err++;
          if (sif.sramDqOut !== (ph ? rm[31:16] : rm[15:0])) bus_err++;
        end else if (sif.sramWeN !== 1'b1 || sif.sramDqOe !== 1'b0) bus_err++;
      end
      if (low > 50) break;
    end
    @(posedge clk); #1;
    n_tests++;
    if (low != (mem ? STALL : 0)) begin
      n_fail++;
      $display("FAIL %s stall_cycles: got %0d want %0d", nm, low, mem ? STALL : 0);
    end
    n_tests++;
    if (bus_err != 0) begin
      n_fail++;
      $display("FAIL %s sram_bus: %0d bad cycles, want 0", nm, bus_err);
    end
    n_tests++;
    if ({wbEnOut, memREnOut, aluResOut, destOut, memDataOut} !== {wb, r, alu, dest, exp_mem_data}) begin
      n_fail++;
      $display("FAIL %s outputs: got wb=%b mr=%b alu=%h dest=%h data=%h want wb=%b mr=%b alu=%h dest=%h data=%h",
               nm, wbEnOut, memREnOut, aluResOut, destOut, memDataOut, wb, r, alu, dest, exp_mem_data);
    end
  endtask

  task automatic idle_inputs();
    wbEnIn = 0; memREnIn = 0; memWEnIn = 0;
    aluResIn = '0; valRmIn = '0; destIn = '0;
  endtask

  task automatic check_reset_state(input string nm);
    n_tests++;
    if ({ready, sif.sramWeN, sif.sramDqOe, sif.sramAddr, wbEnOut, memREnOut, aluResOut, destOut, memDataOut}
        !== {1'b1, 1'b1, 1'b0, {SRAM_AW{1'b0}}, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL %s reset_state: got rdy=%b wen=%b oe=%b addr=%h wb=%b mr=%b alu=%h dest=%h data=%h want rdy=1 wen=1 oe=0 rest 0",
               nm, ready, sif.sramWeN, sif.sramDqOe, sif.sramAddr, wbEnOut, memREnOut, aluResOut, destOut, memDataOut);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 0;
    exp_mem_data = '0;
    @(posedge clk); #1;
    check_reset_state("reset_release");
  endtask

  task automatic test_alu();
    do_op("alu", 1'b1, 1'b0, 1'b0, 32'h12, 32'h0, 4'd3);
    do_op("alu2", 1'b0, 1'b0, 1'b0, 32'hFFFF_0001, 32'h5A5A, 4'd15);
  endtask

  task automatic test_load();
    dev[2] = 16'hBEEF; dev[3] = 16'hDEAD;
    ref_word[1] = 32'hDEADBEEF;
    do_op("load", 1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd7);
  endtask

  task automatic test_store();
    dev[2] = 16'h0000; dev[3] = 16'h0000;
    do_op("store", 1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4'd1);
    n_tests++;
    if (dev_rd(2) !== 16'hBEEF || dev_rd(3) !== 16'hDEAD) begin
      n_fail++;
      $display("FAIL store sram_contents: got [2]=%h [3]=%h want [2]=beef [3]=dead", dev_rd(2), dev_rd(3));
    end
  endtask

  task automatic test_back_to_back();
    do_op("b2b_store", 1'b0, 1'b0, 1'b1, 32'd1044, 32'hCAFE_F00D, 4'd2);
    do_op("b2b_load", 1'b1, 1'b1, 1'b0, 32'd1044, 32'h0, 4'd9);
    do_op("b2b_alu", 1'b1, 1'b0, 1'b0, 32'h0BAD_0BAD, 32'h0, 4'd4);
    do_op("b2b_both", 1'b1, 1'b1, 1'b1, 32'd1048, 32'h1357_9BDF, 4'd5);
    do_op("b2b_load2", 1'b1, 1'b1, 1'b0, 32'd1049, 32'h0, 4'd6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int t;
      logic [31:0] a;
      t = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) a = $urandom();
      else a = ADDR_BASE + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
      do_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), t == 1 || t == 3, t >= 2,
            a, $urandom(), 4'($urandom_range(0, 15)));
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    dev[18] = 16'hAAAA; dev[19] = 16'h5555;
    wbEnIn = 1; memREnIn = 0; memWEnIn = 1;
    aluResIn = ADDR_BASE + 36; valRmIn = 32'h1234_5678; destIn = 4'd8;
    do begin
      @(negedge clk);
      guard++;
    end while (!(sif.sramAddr == SRAM_AW'(19) && sif.sramWeN === 1'b0) && guard < 20);
    n_tests++;
    if (guard >= 20) begin
      n_fail++;
      $display("FAIL reset_mid hi_phase: not reached within %0d cycles, want < 20", guard);
    end
    rst = 1;
    idle_inputs();
    @(posedge clk); #1;
    check_reset_state("reset_mid");
    rst = 0;
    exp_mem_data = '0;
    repeat (4) @(posedge clk);
    #1;
    check_reset_state("reset_mid_after");
    n_tests++;
    if (dev_rd(19) !== 16'h5555 || dev_rd(18) !== 16'h5678) begin
      n_fail++;
      $display("FAIL reset_mid sram_contents: got [18]=%h [19]=%h want [18]=5678 [19]=5555", dev_rd(18), dev_rd(19));
    end
    ref_word[9] = 32'h5555_5678;
    do_op("reset_mid_load", 1'b1, 1'b1, 1'b0, ADDR_BASE + 36, 32'h0, 4'd10);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
